// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: data-side memory request controller between EX/MEM and an
// SRAM-like bus (req / addr_ok / data_ok).
//   - Latches one request from EX and holds it on the bus until addr_ok.
//   - Counts outstanding transactions and returns data through an in-order
//     response FIFO of depth MAX_OUTST.
//   - A flush squashes every issued, pending or buffered access. Responses
//     that are still in flight are counted in cancel_cnt and dropped on return.
// Optional feature macro: MEM_REQ_ALE_EN. When defined, misaligned half/word
// requests are flagged on req_ale and never accepted. When undefined, req_ale
// is tied low and no alignment check is made.
module mem_req_ctrl #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_accept,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   input  logic        resp_ready,
   input  logic        flush,
   output logic        busy,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        req_ale
);

   localparam int               PTR_W        = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(MAX_OUTST);
   localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(MAX_OUTST - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO     = {PTR_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Advance a FIFO pointer, wrapping at the FIFO depth.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = PTR_ZERO;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Misalignment test: half needs addr[0]==0, word needs addr[1:0]==0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         2'd1:    mis = addr_lo[0];
         2'd2:    mis = (addr_lo != 2'd0);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   state_e            state_q, state_d;
   logic              req_wr_q, req_wr_d;
   logic [1:0]        req_size_q, req_size_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [31:0]       req_addr_q, req_addr_d;
   logic [31:0]       req_wdata_q, req_wdata_d;
   logic              req_cancel_q, req_cancel_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  cancel_cnt_q, cancel_cnt_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [31:0]       fifo_mem_q [MAX_OUTST];
   logic [31:0]       fifo_mem_d [MAX_OUTST];

   logic              ale_s;
   logic              credit_ok_s;
   logic              accept_s;
   logic              addr_hs_s;
   logic              cancel_hit_s;
   logic              push_s;
   logic              pop_s;

`ifdef MEM_REQ_ALE_EN
   assign ale_s = req_valid & is_misaligned(req_size, req_addr[1:0]);
`else
   assign ale_s = 1'b0;
`endif

   // Handshake and credit decode shared by the FSM, counters and FIFO.
   always_comb begin
      credit_ok_s  = (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < CREDIT_LIMIT);
      accept_s     = (state_q == ST_IDLE) & req_valid & ~flush & credit_ok_s & ~ale_s;
      addr_hs_s    = (state_q == ST_REQ) & data_sram_addr_ok;
      // cancel_cnt_q is the pre-flush value: older cancelled returns drain first.
      cancel_hit_s = data_sram_data_ok & (cancel_cnt_q != CNT_ZERO);
      push_s       = data_sram_data_ok & ~cancel_hit_s & ~flush;
      pop_s        = (fifo_cnt_q != CNT_ZERO) & resp_ready;
   end

   // Request FSM: IDLE accepts and latches a request, REQ holds it until addr_ok.
   always_comb begin
      state_d     = state_q;
      req_wr_d    = req_wr_q;
      req_size_d  = req_size_q;
      req_wstrb_d = req_wstrb_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d     = ST_REQ;
               req_wr_d    = req_wr;
               req_size_d  = req_size;
               req_wstrb_d = req_wstrb;
               req_addr_d  = req_addr;
               req_wdata_d = req_wdata;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (data_sram_addr_ok) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outstanding count and squash bookkeeping (cancel_cnt, req_cancel).
   always_comb begin
      outst_d      = outst_q + CNT_W'(addr_hs_s) - CNT_W'(data_sram_data_ok);
      cancel_cnt_d = cancel_cnt_q;
      req_cancel_d = req_cancel_q;
      if (flush) begin
         // Every issued transaction not yet returned, this cycle's events included.
         cancel_cnt_d = outst_q + CNT_W'(addr_hs_s) - CNT_W'(data_sram_data_ok);
         // A request still waiting for addr_ok stays on the bus but is marked dead.
         req_cancel_d = (state_q == ST_REQ) & ~data_sram_addr_ok;
      end else begin
         cancel_cnt_d = cancel_cnt_q - CNT_W'(cancel_hit_s)
                                     + CNT_W'(addr_hs_s & req_cancel_q);
         if (addr_hs_s) begin
            req_cancel_d = 1'b0;
         end else begin
            req_cancel_d = req_cancel_q;
         end
      end
   end

   // Response FIFO: push returned data at the tail, pop at the head, clear on flush.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      fifo_cnt_d = fifo_cnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      if (flush) begin
         fifo_cnt_d = CNT_ZERO;
         wptr_d     = PTR_ZERO;
         rptr_d     = PTR_ZERO;
      end else begin
         fifo_cnt_d = fifo_cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
         if (push_s) begin
            fifo_mem_d[wptr_q] = data_sram_rdata;
            wptr_d             = ptr_inc(wptr_q);
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
         end else begin
            rptr_d = rptr_q;
         end
      end
   end

   // State, request register, counters and FIFO storage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         req_wr_q     <= 1'b0;
         req_size_q   <= 2'd0;
         req_wstrb_q  <= 4'h0;
         req_addr_q   <= 32'h0000_0000;
         req_wdata_q  <= 32'h0000_0000;
         req_cancel_q <= 1'b0;
         outst_q      <= CNT_ZERO;
         cancel_cnt_q <= CNT_ZERO;
         fifo_cnt_q   <= CNT_ZERO;
         wptr_q       <= PTR_ZERO;
         rptr_q       <= PTR_ZERO;
         for (int i = 0; i < MAX_OUTST; i++) begin
            fifo_mem_q[i] <= 32'h0000_0000;
         end
      end else begin
         state_q      <= state_d;
         req_wr_q     <= req_wr_d;
         req_size_q   <= req_size_d;
         req_wstrb_q  <= req_wstrb_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_cancel_q <= req_cancel_d;
         outst_q      <= outst_d;
         cancel_cnt_q <= cancel_cnt_d;
         fifo_cnt_q   <= fifo_cnt_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         fifo_mem_q   <= fifo_mem_d;
      end
   end

   assign req_accept      = accept_s;
   assign req_ale         = ale_s;
   assign resp_valid      = (fifo_cnt_q != CNT_ZERO);
   assign resp_rdata      = fifo_mem_q[rptr_q];
   assign busy            = (state_q == ST_REQ) | (outst_q != CNT_ZERO) | (cancel_cnt_q != CNT_ZERO);
   assign data_sram_req   = (state_q == ST_REQ);
   assign data_sram_wr    = req_wr_q;
   assign data_sram_size  = req_size_q;
   assign data_sram_wstrb = req_wstrb_q;
   assign data_sram_addr  = req_addr_q;
   assign data_sram_wdata = req_wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl. The reference model works at the
// transaction level: one pending request, a queue of in-flight transactions
// (each flagged dead once squashed), and a queue of expected responses.
module tb_mem_req_ctrl;

   localparam int MAX_OUTST = 2;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [3:0]  req_wstrb;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_accept;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_ready;
   logic        flush;
   logic        busy;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        req_ale;

   int checks   = 0;
   int failures = 0;
   int model_err_cnt = 0;

   typedef struct { bit wr; bit dead; } infl_t;
   typedef struct { bit wr; logic [31:0] data; } resp_t;

   // Reference model state
   bit          pend;
   bit          pend_dead;
   bit          pend_wr;
   logic [1:0]  pend_size;
   logic [3:0]  pend_wstrb;
   logic [31:0] pend_addr;
   logic [31:0] pend_wdata;
   infl_t       infl_q[$];
   resp_t       rsp_q[$];

   mem_req_ctrl #(.MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
      .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_accept(req_accept), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_ready(resp_ready), .flush(flush), .busy(busy),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata), .req_ale(req_ale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit model_ale();
`ifdef MEM_REQ_ALE_EN
      int unsigned bytes;
      bytes = 32'd1 << req_size;
      return req_valid && ((req_addr % bytes) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_accept();
      return !pend && req_valid && !flush && !model_ale()
             && ((infl_q.size() + rsp_q.size()) < MAX_OUTST);
   endfunction

   function automatic bit model_busy();
      return pend || (infl_q.size() != 0);
   endfunction

   // Advance one clock and apply the cycle's events to the model.
   task automatic tick();
      bit acc, aok, dok, fl, rdy;
      int pre;
      infl_t e;
      resp_t r;
      logic [31:0] rd;
      acc = model_accept();
      aok = pend && data_sram_addr_ok;
      dok = data_sram_data_ok;
      fl  = flush;
      rdy = resp_ready;
      rd  = data_sram_rdata;
      @(posedge clk);
      pre = rsp_q.size();
      if (pre > 0 && rdy) void'(rsp_q.pop_front());
      if (dok) begin
         if (infl_q.size() == 0) begin
            model_err_cnt++;
         end else begin
            e = infl_q.pop_front();
            if (!e.dead && !fl) begin
               if (pre >= MAX_OUTST) model_err_cnt++;
               r.wr = e.wr; r.data = rd;
               rsp_q.push_back(r);
            end
         end
      end
      if (fl) begin
         rsp_q.delete();
         foreach (infl_q[i]) infl_q[i].dead = 1'b1;
      end
      if (aok) begin
         e.wr = pend_wr; e.dead = pend_dead || fl;
         infl_q.push_back(e);
         pend = 1'b0;
      end else if (fl && pend) begin
         pend_dead = 1'b1;
      end
      if (acc) begin
         pend = 1'b1; pend_dead = 1'b0;
         pend_wr = req_wr; pend_size = req_size; pend_wstrb = req_wstrb;
         pend_addr = req_addr; pend_wdata = req_wdata;
      end
      @(negedge clk);
   endtask

   task automatic drive_load(input logic [31:0] a);
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2;
      req_wstrb = 4'h0; req_addr = a; req_wdata = 32'h0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_wstrb = 4'h0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; flush = 1'b0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      pend = 1'b0; pend_dead = 1'b0;
      #2;
      checks++; if ({req_accept, resp_valid, busy, data_sram_req} !== 4'b0000) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {req_accept, resp_valid, busy, data_sram_req}); end
      checks++; if (data_sram_addr !== 32'h0 || data_sram_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", data_sram_addr, data_sram_wdata, resp_rdata); end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || data_sram_req !== 1'b0) begin
         failures++; $display("FAIL reset_release busy=%b req=%b exp=0", busy, data_sram_req); end
   endtask

   task automatic test_single_load();
      drive_load(32'h1C00_0100);
      #1;
      checks++; if (req_accept !== 1'b1) begin failures++; $display("FAIL load_accept got=%b exp=1", req_accept); end
      tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1;
      #1;
      checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1C00_0100) begin
         failures++; $display("FAIL load_bus req=%b addr=%h exp=1/1c000100", data_sram_req, data_sram_addr); end
      tick();
      data_sram_addr_ok = 1'b0;
      tick();
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
      tick();
      data_sram_data_ok = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL load_resp valid=%b rdata=%h exp=1/deadbeef", resp_valid, resp_rdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_busy got=%b exp=0", busy); end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL load_pop got=%b exp=0", resp_valid); end
   endtask

   task automatic test_addr_stall();
      drive_load(32'h1C00_0100);
      tick();
      req_addr = 32'h1C00_0200;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1C00_0100 || req_accept !== 1'b0) begin
            failures++; $display("FAIL stall_hold cyc=%0d req=%b addr=%h acc=%b exp=1/1c000100/0", i, data_sram_req, data_sram_addr, req_accept); end
         tick();
      end
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; tick(); data_sram_data_ok = 1'b0;
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
   endtask

   task automatic test_credit();
      drive_load(32'h0000_0A00); tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      drive_load(32'h0000_0B00); tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001; tick();
      data_sram_rdata = 32'hBBBB_0002; tick(); data_sram_data_ok = 1'b0;
      drive_load(32'h0000_0C00);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (req_accept !== 1'b0) begin failures++; $display("FAIL credit_block cyc=%0d got=%b exp=0", i, req_accept); end
         tick();
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hAAAA_0001) begin
         failures++; $display("FAIL credit_popA valid=%b rdata=%h exp=1/aaaa0001", resp_valid, resp_rdata); end
      tick();
      req_valid = 1'b1;
      #1;
      checks++; if (req_accept !== 1'b1) begin failures++; $display("FAIL credit_free got=%b exp=1", req_accept); end
      checks++; if (resp_rdata !== 32'hBBBB_0002) begin failures++; $display("FAIL credit_popB got=%h exp=bbbb0002", resp_rdata); end
      req_valid = 1'b0;
      tick(); resp_ready = 1'b0;
   endtask

   task automatic test_flush_pending();
      drive_load(32'h0000_1000); tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      drive_load(32'h0000_2000); tick();
      req_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
      #1;
      checks++; if (data_sram_req !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0) begin
         failures++; $display("FAIL flush_hold req=%b busy=%b rv=%b exp=1/1/0", data_sram_req, busy, resp_valid); end
      tick(); tick();
      data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_0001; tick();
      data_sram_data_ok = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL flush_drop1 rv=%b busy=%b exp=0/1", resp_valid, busy); end
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_0002; tick(); data_sram_data_ok = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL flush_drop2 rv=%b busy=%b exp=0/0", resp_valid, busy); end
      drive_load(32'h0000_3000); tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_0003; tick(); data_sram_data_ok = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h7777_0003) begin
         failures++; $display("FAIL flush_after rv=%b rdata=%h exp=1/77770003", resp_valid, resp_rdata); end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
   endtask

   task automatic test_flush_data_ok();
      drive_load(32'h0000_4000); tick();
      req_valid = 1'b0; data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
      drive_load(32'h0000_5000);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9999_0001; flush = 1'b1;
      #1;
      checks++; if (req_accept !== 1'b0) begin failures++; $display("FAIL fdok_accept got=%b exp=0", req_accept); end
      tick();
      req_valid = 1'b0; data_sram_data_ok = 1'b0; flush = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || data_sram_req !== 1'b0) begin
         failures++; $display("FAIL fdok_state rv=%b busy=%b req=%b exp=0/0/0", resp_valid, busy, data_sram_req); end
   endtask

   task automatic test_ale();
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd1; req_wstrb = 4'b1000;
      req_addr = 32'h1C00_0103; req_wdata = 32'h1234_5678;
      #1;
`ifdef MEM_REQ_ALE_EN
      checks++; if (req_ale !== 1'b1 || req_accept !== 1'b0) begin
         failures++; $display("FAIL ale_flag ale=%b acc=%b exp=1/0", req_ale, req_accept); end
      tick(); req_valid = 1'b0;
      #1;
      checks++; if (data_sram_req !== 1'b0) begin failures++; $display("FAIL ale_noreq got=%b exp=0", data_sram_req); end
`else
      checks++; if (req_ale !== 1'b0 || req_accept !== 1'b1) begin
         failures++; $display("FAIL ale_off ale=%b acc=%b exp=0/1", req_ale, req_accept); end
      tick(); req_valid = 1'b0; data_sram_addr_ok = 1'b1;
      #1;
      checks++; if (data_sram_addr !== 32'h1C00_0103 || data_sram_wr !== 1'b1 || data_sram_size !== 2'd1) begin
         failures++; $display("FAIL ale_off_bus addr=%h wr=%b size=%0d exp=1c000103/1/1", data_sram_addr, data_sram_wr, data_sram_size); end
      tick(); data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1; tick(); data_sram_data_ok = 1'b0;
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
`endif
   endtask

   task automatic test_random();
      bit exp_acc;
      for (int cyc = 0; cyc < 800; cyc++) begin
         req_valid = ($urandom_range(0, 1) == 1);
         req_wr    = 1'($urandom_range(0, 1));
         req_size  = 2'($urandom_range(0, 2));
         req_wstrb = 4'($urandom_range(0, 15));
         req_addr  = $urandom;
         if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~((32'd1 << req_size) - 32'd1);
         req_wdata = $urandom;
         flush      = ($urandom_range(0, 19) == 0);
         resp_ready = ($urandom_range(0, 9) < 6);
         data_sram_addr_ok = pend && ($urandom_range(0, 1) == 1);
         data_sram_data_ok = (infl_q.size() != 0) && ($urandom_range(0, 9) < 4);
         data_sram_rdata   = $urandom;
         #1;
         exp_acc = model_accept();
         checks++; if (req_accept !== exp_acc) begin
            failures++; $display("FAIL rnd_accept cyc=%0d got=%b exp=%b", cyc, req_accept, exp_acc); end
         checks++; if (req_ale !== model_ale()) begin
            failures++; $display("FAIL rnd_ale cyc=%0d got=%b exp=%b", cyc, req_ale, model_ale()); end
         checks++; if (data_sram_req !== pend) begin
            failures++; $display("FAIL rnd_busreq cyc=%0d got=%b exp=%b", cyc, data_sram_req, pend); end
         if (pend) begin
            checks++; if ({data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}
                          !== {pend_wr, pend_size, pend_wstrb, pend_addr, pend_wdata}) begin
               failures++; $display("FAIL rnd_payload cyc=%0d got=%b/%0d/%h/%h/%h exp=%b/%0d/%h/%h/%h", cyc,
                  data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
                  pend_wr, pend_size, pend_wstrb, pend_addr, pend_wdata); end
         end
         checks++; if (resp_valid !== (rsp_q.size() != 0)) begin
            failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, resp_valid, rsp_q.size() != 0); end
         if (rsp_q.size() != 0 && !rsp_q[0].wr) begin
            checks++; if (resp_rdata !== rsp_q[0].data) begin
               failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, resp_rdata, rsp_q[0].data); end
         end
         checks++; if (busy !== model_busy()) begin
            failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, model_busy()); end
         tick();
      end
      req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         data_sram_addr_ok = pend;
         data_sram_data_ok = (infl_q.size() != 0);
         data_sram_rdata   = $urandom;
         tick();
      end
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; resp_ready = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || data_sram_req !== 1'b0) begin
         failures++; $display("FAIL rnd_drain busy=%b rv=%b req=%b exp=0/0/0", busy, resp_valid, data_sram_req); end
      checks++; if (model_err_cnt !== 0) begin
         failures++; $display("FAIL fifo_credit overflow_or_underflow_events=%0d exp=0", model_err_cnt); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_single_load();
      test_addr_stall();
      test_credit();
      test_flush_pending();
      test_flush_data_ok();
      test_ale();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
Controller between the EX/MEM pipeline stages and the data-side SRAM-like bus (req/addr_ok/data_ok).
- Latches a memory request from EX and holds it stable on the bus until addr_ok.
- Tracks outstanding transactions and returns read data to MEM through an in-order response FIFO.
- Discards responses belonging to instructions squashed by a pipeline flush.

Parameters:
MAX_OUTST, 2, max in-flight accesses (issued but no data_ok) plus buffered responses; also response FIFO depth
CNT_W, 2, width of outstanding/cancel/FIFO counters; must hold MAX_OUTST

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
req_valid  in  1  EX has a load/store ready to issue
req_wr  in  1  1 = store
req_size  in  2  0 = byte, 1 = half, 2 = word
req_wstrb  in  4  byte write enables
req_addr  in  32  byte address
req_wdata  in  32  store data
req_accept  out  1  request taken this cycle; EX may advance
resp_valid  out  1  head of response FIFO valid
resp_rdata  out  32  head response data (loads; stores return don't-care data)
resp_ready  in  1  MEM consumes head response this cycle
flush  in  1  squash all in-flight/buffered accesses (exception/ertn)
busy  out  1  any request pending, outstanding, or cancel pending
data_sram_req  out  1  bus request
data_sram_wr  out  1  bus write
data_sram_size  out  2  bus size
data_sram_wstrb  out  4  bus strobes
data_sram_addr  out  32  bus address
data_sram_wdata  out  32  bus write data
data_sram_addr_ok  in  1  address handshake
data_sram_data_ok  in  1  data return, in order
data_sram_rdata  in  32  return data
req_ale  out  1  misaligned request flag (see Optional Feature)

Behaviour:
- Reset (async, resetn=0): state=IDLE; outst, cancel_cnt, FIFO count/pointers = 0; req_cancel=0. Outputs req_accept, resp_valid, busy, data_sram_req = 0; data_sram_* payload and resp_rdata = 0.
- States: IDLE, REQ.
- IDLE:
  - req_accept = req_valid & ~flush & (outst + fifo_cnt < MAX_OUTST), combinational.
  - On accept: latch wr/size/wstrb/addr/wdata into the request register; next state REQ.
- REQ:
  - data_sram_req=1; payload driven from the request register and stable until addr_ok.
  - On addr_ok: outst+1; if req_cancel then cancel_cnt+1 and clear req_cancel; go IDLE.
  - No new accept in REQ. Minimum issue spacing is 2 cycles (accept at T, bus req at T+1, earliest addr_ok T+1).
- data_ok:
  - Always: outst-1.
  - If cancel_cnt>0 (before this cycle's flush update): cancel_cnt-1, data dropped.
  - Else if ~flush: rdata pushed to FIFO tail.
- FIFO:
  - Depth MAX_OUTST; pointers wrap modulo depth.
  - Pop when resp_valid & resp_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees no push when full and no pop when empty; a bench assertion checks both.
- flush, cycle T:
  - FIFO cleared and resp_valid=0 from T+1.
  - cancel_cnt <= outst + addr_ok_in_REQ - data_ok, i.e. every issued transaction not yet returned, counting this cycle's events.
  - If REQ and no addr_ok this cycle: req_cancel=1. The bus request is never withdrawn mid-handshake; on its later addr_ok it is counted into cancel_cnt.
  - Same-cycle data_ok is dropped.
- flush while IDLE with req_valid: no accept.
- A new request may be accepted while cancel_cnt>0 because responses are in order; credit uses outst, which includes cancelled transactions.
- busy = (state==REQ) | (outst!=0) | (cancel_cnt!=0).

Optional Feature:
Macro MEM_REQ_ALE_EN.
- Defined: req_ale = req_valid & ((size==1 & addr[0]) | (size==2 & addr[1:0]!=0)). A misaligned request is never accepted (req_accept forced 0); EX raises ALE.
- Undefined: req_ale tied 0 and no alignment check.

Test Plan:
1. Word load at 0x1C000100; addr_ok at T+1, data_ok at T+3 with rdata 0xDEADBEEF -> req_accept at T; resp_valid=1, resp_rdata=0xDEADBEEF at T+4; outst back to 0.
2. addr_ok held low 5 cycles -> data_sram_req stays 1 and data_sram_addr stays 0x1C000100 every cycle; no second accept.
3. MAX_OUTST=2, two loads issued, resp_ready=0 -> third req_valid gets req_accept=0 until one FIFO entry pops; responses pop in order A, B.
4. flush while REQ is still waiting for addr_ok; one older load outstanding -> addr_ok then 2 data_ok cycles -> resp_valid stays 0, cancel_cnt goes 2->0, busy drops afterwards.
5. flush in the same cycle as data_ok, plus req_valid in that cycle -> data dropped, FIFO empty, req_accept=0.
6. MEM_REQ_ALE_EN defined: half store at 0x...03 -> req_ale=1, req_accept=0, data_sram_req never asserted; with the macro undefined, same request accepted.
